ps2_host_tx: RTL
================

Name: ps2_host_tx

Overview:
- Memory-mapped PS/2 host-to-device transmitter. It is the send direction opposite the keyboard receive converter.
- The processor writes command bytes (e.g. 0xED set-LEDs, 0xFF reset) to a TX address. Bytes queue in a 4-entry FIFO and are sent over the PS/2 clock/data lines using open-drain drive.
- A status word is readable on the shared 64-bit data bus.
- Sits on the processor bus beside the GPU and GPIO blocks, clocked by clock25.

Parameters:
- TX_ADDRESS, 64'hFFFF_0020, bus address; a write here enqueues data[7:0].
- STATUS_ADDRESS, 64'hFFFF_0028, bus address; a read here returns the status word.
- INHIBIT_CYCLES, 2500, clock cycles the PS/2 clock is held low before the request (100 us at 25 MHz).
- TIMEOUT_CYCLES, 375000, maximum cycles between device clock falling edges, and before the first edge (15 ms).

Ports:
- clock  in  1  system clock (clock25)
- reset  in  1  synchronous, active-high reset
- data  inout  64  shared bus; driven only during a status read, otherwise high-Z
- address  in  64  bus address
- read  in  1  bus read strobe
- write  in  1  bus write strobe
- kbclk_in  in  1  PS/2 clock pin value (asynchronous)
- kbdat_in  in  1  PS/2 data pin value (asynchronous)
- kbclk_oe  out  1  1 = pull PS/2 clock low
- kbdat_oe  out  1  1 = pull PS/2 data low

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset state: kbclk_oe=0, kbdat_oe=0, FIFO empty, all sticky flags 0, state IDLE, data high-Z.
- Reset mid-transfer: both lines are released on the next edge and the byte in flight is discarded.
- Input synchronisation:
  - kbclk_in and kbdat_in each pass through a 2-FF synchroniser.
  - A falling edge is detected as previous sync = 1, current sync = 0.
- Bus write:
  - When write && address==TX_ADDRESS, data[7:0] is enqueued on that edge.
  - If the FIFO is full, the byte is dropped and sticky overflow is set.
- Bus read:
  - When read && address==STATUS_ADDRESS, data is driven combinationally with {59'b0, overflow, timeout_err, ack_err, fifo_full, busy}.
  - busy = FIFO non-empty OR state != IDLE.
  - Sticky bits clear on the first cycle after the read-hit deasserts. A set event in that same cycle wins.
- FIFO:
  - 4 entries × 8 bits; pointers are 2 bits plus a count.
  - A simultaneous push and pop when full is accepted, with no overflow.
- Frame: start bit 0, d0..d7 (LSB first), odd parity (~^byte), stop bit 1, then the device ACK.
- FSM states and transitions:
  - IDLE: when the FIFO is non-empty, pop into the shift register, clear the counter, go to INHIBIT.
  - INHIBIT: kbclk_oe=1 for INHIBIT_CYCLES cycles, then go to REQ.
  - REQ: kbclk_oe=1, kbdat_oe=1 for 1 cycle (start bit).
  - SEND: kbclk_oe=0 (clock released); kbdat_oe still reflects the start bit.
    - On falling edge k (k=1..9), kbdat_oe = ~bit[k-1] of {parity, d7..d0}.
    - On edge 10, kbdat_oe=0 (stop bit).
    - Then go to ACK.
  - ACK: on the next falling edge (edge 11), sample synced data.
    - 0 means ACK.
    - 1 means set ack_err.
    - Either way, go to WAIT_IDLE.
  - WAIT_IDLE: wait until synced clock and data are both 1, then go to IDLE.
- Timeout:
  - In SEND, ACK and WAIT_IDLE, a counter resets on every falling edge.
  - Reaching TIMEOUT_CYCLES sets timeout_err, releases both lines and goes to IDLE.
  - The byte is lost; the next FIFO entry proceeds normally.
- Counter width is $clog2(max(INHIBIT_CYCLES, TIMEOUT_CYCLES)+1). The counter saturates and never wraps.

Decomposition:
- Package ps2_host_pkg holds:
  - state enum {IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE};
  - status bit index constants (BUSY=0, FULL=1, ACK_ERR=2, TIMEOUT_ERR=3, OVERFLOW=4);
  - FIFO_DEPTH=4.
- One sub-module, ps2_tx_fifo: a synchronous 4×8 FIFO with push/pop/full/empty.

Test Plan:
- Write 0xED; the device model clocks at 12.5 kHz and ACKs.
  - Expect kbclk_oe low for exactly 2500 cycles, then the start bit.
  - Expect released-data bits 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - Final status = 0x0.
- Write 0x00 with no ACK (device leaves data high at edge 11).
  - Parity bit = 1.
  - Status reads 0x4; after the read deasserts, status reads 0x0.
- Write 0xFF with no device clocking.
  - After 2501 + 375000 cycles, both oe = 0 and status = 0x8.
- Write 0x01..0x05 back-to-back while busy.
  - Status shows full=1 (0x3) after the 4th write and overflow set (0x13) after the 5th.
  - Device observes 0x01..0x04 in order; 0x05 is never sent.
- Assert reset at edge 5 of a transfer.
  - Next cycle: kbclk_oe=0, kbdat_oe=0, status=0x0, FIFO empty, no further line activity.
- Read address ≠ STATUS_ADDRESS with read=1.
  - data stays high-Z.
  - A write to a non-TX address leaves the FIFO unchanged.

Source files
------------

// File: rtl/ps2_host_pkg.sv
// ps2_host_pkg
// Shared types and constants for the PS/2 host transmitter slice.
//   state_t       : transmitter FSM states
//   BUSY..OVERFLOW: bit positions inside the 64-bit status word
//   FIFO_DEPTH    : number of queued command bytes
//   odd_parity()  : PS/2 frame parity bit for a data byte
package ps2_host_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        REQ       = 3'd2,
        SEND      = 3'd3,
        ACK       = 3'd4,
        WAIT_IDLE = 3'd5
    } state_t;

    localparam int BUSY        = 0;
    localparam int FULL        = 1;
    localparam int ACK_ERR     = 2;
    localparam int TIMEOUT_ERR = 3;
    localparam int OVERFLOW    = 4;

    localparam int FIFO_DEPTH  = 4;
    localparam int FIFO_PTR_W  = 2;
    localparam int FIFO_CNT_W  = 3;

    // PS/2 uses odd parity: the parity bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] value);
        return ~^value;
    endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// ps2_tx_fifo
// Synchronous 4 x 8 FIFO holding command bytes waiting to be sent.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   push         : enqueue push_data (ignored when full unless popping too)
//   push_data    : byte to enqueue
//   pop          : dequeue the head entry (ignored when empty)
//   pop_data     : current head entry (valid when not empty)
//   full, empty  : occupancy flags
module ps2_tx_fifo
    import ps2_host_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] pop_data,
    output logic       full,
    output logic       empty
);

    localparam logic [FIFO_CNT_W-1:0] FULL_COUNT = FIFO_CNT_W'(FIFO_DEPTH);

    logic [7:0]            mem_r [FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0] wr_ptr_r;
    logic [FIFO_PTR_W-1:0] rd_ptr_r;
    logic [FIFO_CNT_W-1:0] count_r;
    logic                  do_push_s;
    logic                  do_pop_s;

    assign empty    = (count_r == {FIFO_CNT_W{1'b0}});
    assign full     = (count_r == FULL_COUNT);
    assign do_pop_s = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push_s = push && (!full || do_pop_s);
    assign pop_data = mem_r[rd_ptr_r];

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r <= {FIFO_PTR_W{1'b0}};
            rd_ptr_r <= {FIFO_PTR_W{1'b0}};
            count_r  <= {FIFO_CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + FIFO_PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + FIFO_PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + FIFO_CNT_W'(1);
                2'b01:   count_r <= count_r - FIFO_CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clock) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx
// Memory-mapped PS/2 host-to-device transmitter. Bytes written to TX_ADDRESS
// are queued and sent as PS/2 host frames (start, d0..d7, odd parity, stop,
// device ACK) using open-drain drive of the clock and data lines.
// Ports:
//   clock, reset        : system clock (clock25), synchronous active-high reset
//   data   [63:0] inout : shared bus; status word driven only on a status read
//   address[63:0]       : bus address
//   read, write         : bus strobes
//   kbclk_in, kbdat_in  : PS/2 pin values (asynchronous)
//   kbclk_oe, kbdat_oe  : 1 = pull the PS/2 clock / data line low
// Status word: {59'b0, overflow, timeout_err, ack_err, fifo_full, busy}
module ps2_host_tx
    import ps2_host_pkg::*;
#(
    parameter logic [63:0] TX_ADDRESS     = 64'hFFFF_0020,
    parameter logic [63:0] STATUS_ADDRESS = 64'hFFFF_0028,
    parameter int          INHIBIT_CYCLES = 2500,
    parameter int          TIMEOUT_CYCLES = 375000
) (
    input  logic        clock,
    input  logic        reset,
    inout  wire  [63:0] data,
    input  logic [63:0] address,
    input  logic        read,
    input  logic        write,
    input  logic        kbclk_in,
    input  logic        kbdat_in,
    output logic        kbclk_oe,
    output logic        kbdat_oe
);

    localparam int CNT_LIMIT = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W     = $clog2(CNT_LIMIT + 1);
    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT      = {CNT_W{1'b1}};
    localparam logic [3:0]       LAST_DATA_EDGE = 4'd9;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        if (value == CNT_SAT) begin
            return value;
        end else begin
            return value + CNT_W'(1);
        end
    endfunction

    // Synchronisers and edge detect
    logic   kbclk_meta_r, kbclk_sync_r, kbclk_prev_r;
    logic   kbdat_meta_r, kbdat_sync_r;
    logic   clk_fall_s;

    // FSM state and datapath
    state_t           state_r,    state_s;
    logic [CNT_W-1:0] cnt_r,      cnt_s;
    logic [8:0]       shift_r,    shift_s;
    logic [3:0]       edge_cnt_r, edge_cnt_s;
    logic             kbclk_oe_r, kbclk_oe_s;
    logic             kbdat_oe_r, kbdat_oe_s;

    // Bus side and status
    logic        tx_hit_s, read_hit_s, read_hit_prev_r, sticky_clr_s;
    logic        fifo_pop_s, fifo_full_s, fifo_empty_s;
    logic [7:0]  fifo_data_s;
    logic        ack_err_r, timeout_err_r, overflow_r;
    logic        ack_err_set_s, timeout_set_s, overflow_set_s;
    logic        busy_s;
    logic [63:0] status_s;

    assign tx_hit_s   = write && (address == TX_ADDRESS);
    assign read_hit_s = read && (address == STATUS_ADDRESS);
    assign clk_fall_s = kbclk_prev_r && !kbclk_sync_r;

    ps2_tx_fifo u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (tx_hit_s),
        .push_data (data[7:0]),
        .pop       (fifo_pop_s),
        .pop_data  (fifo_data_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    // Two-flop synchronisers for both pins plus the previous clock sample
    always_ff @(posedge clock) begin
        if (reset) begin
            kbclk_meta_r <= 1'b1;
            kbclk_sync_r <= 1'b1;
            kbclk_prev_r <= 1'b1;
            kbdat_meta_r <= 1'b1;
            kbdat_sync_r <= 1'b1;
        end else begin
            kbclk_meta_r <= kbclk_in;
            kbclk_sync_r <= kbclk_meta_r;
            kbclk_prev_r <= kbclk_sync_r;
            kbdat_meta_r <= kbdat_in;
            kbdat_sync_r <= kbdat_meta_r;
        end
    end

    // Next-state, counter and next-output logic of the transmit FSM
    always_comb begin
        state_s       = state_r;
        cnt_s         = cnt_r;
        shift_s       = shift_r;
        edge_cnt_s    = edge_cnt_r;
        kbclk_oe_s    = 1'b0;
        kbdat_oe_s    = 1'b0;
        fifo_pop_s    = 1'b0;
        ack_err_set_s = 1'b0;
        timeout_set_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s) begin
                    fifo_pop_s = 1'b1;
                    shift_s    = {odd_parity(fifo_data_s), fifo_data_s};
                    cnt_s      = {CNT_W{1'b0}};
                    edge_cnt_s = 4'd0;
                    kbclk_oe_s = 1'b1;
                    state_s    = INHIBIT;
                end else begin
                    state_s    = IDLE;
                end
            end
            INHIBIT: begin
                kbclk_oe_s = 1'b1;
                if (cnt_r == INHIBIT_LAST) begin
                    // Pull data low while the clock is still held: start bit
                    kbdat_oe_s = 1'b1;
                    cnt_s      = {CNT_W{1'b0}};
                    state_s    = REQ;
                end else begin
                    cnt_s      = sat_inc(cnt_r);
                end
            end
            REQ: begin
                // Release the clock; data stays low so the device clocks us.
                kbdat_oe_s = 1'b1;
                cnt_s      = {CNT_W{1'b0}};
                state_s    = SEND;
            end
            SEND: begin
                kbdat_oe_s = kbdat_oe_r;
                if (clk_fall_s) begin
                    cnt_s      = {CNT_W{1'b0}};
                    edge_cnt_s = edge_cnt_r + 4'd1;
                    if (edge_cnt_r == LAST_DATA_EDGE) begin
                        // Tenth falling edge: present the stop bit (released line)
                        kbdat_oe_s = 1'b0;
                        state_s    = ACK;
                    end else begin
                        // Shift in ones so the register drains to the stop level.
                        kbdat_oe_s = ~shift_r[0];
                        shift_s    = {1'b1, shift_r[8:1]};
                    end
                end else if (cnt_r == TIMEOUT_LAST) begin
                    kbdat_oe_s    = 1'b0;
                    timeout_set_s = 1'b1;
                    state_s       = IDLE;
                end else begin
                    cnt_s = sat_inc(cnt_r);
                end
            end
            ACK: begin
                if (clk_fall_s) begin
                    ack_err_set_s = kbdat_sync_r;
                    cnt_s         = {CNT_W{1'b0}};
                    state_s       = WAIT_IDLE;
                end else if (cnt_r == TIMEOUT_LAST) begin
                    timeout_set_s = 1'b1;
                    state_s       = IDLE;
                end else begin
                    cnt_s = sat_inc(cnt_r);
                end
            end
            WAIT_IDLE: begin
                if (kbclk_sync_r && kbdat_sync_r) begin
                    state_s = IDLE;
                end else if (clk_fall_s) begin
                    cnt_s = {CNT_W{1'b0}};
                end else if (cnt_r == TIMEOUT_LAST) begin
                    timeout_set_s = 1'b1;
                    state_s       = IDLE;
                end else begin
                    cnt_s = sat_inc(cnt_r);
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FSM state, datapath and registered open-drain enables
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            shift_r    <= 9'd0;
            edge_cnt_r <= 4'd0;
            kbclk_oe_r <= 1'b0;
            kbdat_oe_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            shift_r    <= shift_s;
            edge_cnt_r <= edge_cnt_s;
            kbclk_oe_r <= kbclk_oe_s;
            kbdat_oe_r <= kbdat_oe_s;
        end
    end

    assign kbclk_oe = kbclk_oe_r;
    assign kbdat_oe = kbdat_oe_r;

    // A byte written while full is dropped unless the FSM pops that cycle.
    assign overflow_set_s = tx_hit_s && fifo_full_s && !fifo_pop_s;
    // Sticky bits clear once the status read has ended.
    assign sticky_clr_s   = read_hit_prev_r && !read_hit_s;

    // Sticky error flags; a set in the clearing cycle takes priority
    always_ff @(posedge clock) begin
        if (reset) begin
            read_hit_prev_r <= 1'b0;
            ack_err_r       <= 1'b0;
            timeout_err_r   <= 1'b0;
            overflow_r      <= 1'b0;
        end else begin
            read_hit_prev_r <= read_hit_s;
            ack_err_r       <= ack_err_set_s  ? 1'b1 : (sticky_clr_s ? 1'b0 : ack_err_r);
            timeout_err_r   <= timeout_set_s  ? 1'b1 : (sticky_clr_s ? 1'b0 : timeout_err_r);
            overflow_r      <= overflow_set_s ? 1'b1 : (sticky_clr_s ? 1'b0 : overflow_r);
        end
    end

    assign busy_s = !fifo_empty_s || (state_r != IDLE);

    // Status word assembly
    always_comb begin
        status_s              = 64'd0;
        status_s[BUSY]        = busy_s;
        status_s[FULL]        = fifo_full_s;
        status_s[ACK_ERR]     = ack_err_r;
        status_s[TIMEOUT_ERR] = timeout_err_r;
        status_s[OVERFLOW]    = overflow_r;
    end

    assign data = read_hit_s ? status_s : {64{1'bz}};

endmodule
